// File: rtl/mem_port_arbiter.sv
// Purpose: shares one variable-latency memory between two requesters (port 0 = CPU, port 1 = loader/debug).
// Latency: grant on the sampling edge, done at least 2 cycles after the request; 3 cycles minimum per transaction.
// Backpressure: req is held until done; the losing port waits and is ignored outside IDLE; a timeout bounds memory stalls.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   req*/we*/addr*/wdata*          per-port request, held stable until done
//   gnt*/done*/err/rdata           per-port grant, one-cycle done pulse, timeout flag and read data
//   mem_req/mem_we/mem_addr/mem_wdata/mem_rdata/mem_ready   memory-side transaction interface
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          done0,
    output logic          done1,
    output logic          err,
    output logic [DW-1:0] rdata,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready
);

    // Counter only needs to hold 0..TIMEOUT-1.
    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic          last, last_nxt;     // last port served
    logic          owner, owner_nxt;   // port holding the memory
    logic [CW-1:0] cnt, cnt_nxt;
    logic          win;

    logic          gnt0_nxt, gnt1_nxt, done0_nxt, done1_nxt, err_nxt;
    logic [DW-1:0] rdata_nxt;
    logic          mem_req_nxt, mem_we_nxt;
    logic [AW-1:0] mem_addr_nxt;
    logic [DW-1:0] mem_wdata_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            last      <= 1'b1;     // port 0 wins the first tie
            owner     <= 1'b0;
            cnt       <= '0;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            done0     <= 1'b0;
            done1     <= 1'b0;
            err       <= 1'b0;
            rdata     <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state     <= state_nxt;
            last      <= last_nxt;
            owner     <= owner_nxt;
            cnt       <= cnt_nxt;
            gnt0      <= gnt0_nxt;
            gnt1      <= gnt1_nxt;
            done0     <= done0_nxt;
            done1     <= done1_nxt;
            err       <= err_nxt;
            rdata     <= rdata_nxt;
            mem_req   <= mem_req_nxt;
            mem_we    <= mem_we_nxt;
            mem_addr  <= mem_addr_nxt;
            mem_wdata <= mem_wdata_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        last_nxt      = last;
        owner_nxt     = owner;
        cnt_nxt       = cnt;
        win           = 1'b0;
        gnt0_nxt      = gnt0;
        gnt1_nxt      = gnt1;
        done0_nxt     = 1'b0;
        done1_nxt     = 1'b0;
        err_nxt       = err;
        rdata_nxt     = rdata;
        mem_req_nxt   = mem_req;
        mem_we_nxt    = mem_we;
        mem_addr_nxt  = mem_addr;
        mem_wdata_nxt = mem_wdata;

        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    // Port 1 wins when alone, or on a tie when port 0 was served last.
                    win           = req1 & (~req0 | ~last);
                    owner_nxt     = win;
                    last_nxt      = win;
                    cnt_nxt       = '0;
                    gnt0_nxt      = ~win;
                    gnt1_nxt      = win;
                    mem_req_nxt   = 1'b1;
                    mem_we_nxt    = win ? we1 : we0;
                    mem_addr_nxt  = win ? addr1 : addr0;
                    mem_wdata_nxt = win ? wdata1 : wdata0;
                    state_nxt     = BUSY;
                end
            end
            BUSY: begin
                // mem_ready takes precedence over a timeout on the same cycle.
                if (mem_ready) begin
                    if (!mem_we) begin
                        rdata_nxt = mem_rdata;
                    end
                    err_nxt     = 1'b0;
                    done0_nxt   = ~owner;
                    done1_nxt   = owner;
                    mem_req_nxt = 1'b0;
                    state_nxt   = DONE;
                end else if (cnt == CNT_LAST) begin
                    err_nxt     = 1'b1;
                    done0_nxt   = ~owner;
                    done1_nxt   = owner;
                    mem_req_nxt = 1'b0;
                    state_nxt   = DONE;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            DONE: begin
                gnt0_nxt  = 1'b0;
                gnt1_nxt  = 1'b0;
                state_nxt = IDLE;
            end
            default: begin
                gnt0_nxt    = 1'b0;
                gnt1_nxt    = 1'b0;
                mem_req_nxt = 1'b0;
                state_nxt   = IDLE;
            end
        endcase
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-port arbiter and sequencer for the single unified memory of the multicycle datapath. It shares that memory between the CPU controller's fetch/load/store path (port 0) and the program loader/debug port (port 1). It runs a request/grant/done handshake, alternates fairly between the ports, and drives one variable-latency memory transaction at a time. A timeout aborts a transaction if the memory never answers.

## Interface
Parameters:
- AW, 32, address width
- DW, 32, data width
- TIMEOUT, 255, maximum BUSY cycles to wait for mem_ready before aborting (≥1)

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- req0 / req1  in  1  port request; held high until done
- we0 / we1  in  1  1 = write, 0 = read; stable while req is high
- addr0 / addr1  in  AW  byte address; stable while req is high
- wdata0 / wdata1  in  DW  write data; stable while req is high
- gnt0 / gnt1  out  1  port owns the memory (BUSY or DONE)
- done0 / done1  out  1  one-cycle completion pulse to the owning port
- err  out  1  valid with a done pulse; 1 = the transaction timed out
- rdata  out  DW  registered read data; valid while a done pulse is high on a read
- mem_req  out  1  transaction active toward memory
- mem_we  out  1  registered copy of the owner's we
- mem_addr  out  AW  registered copy of the owner's addr
- mem_wdata  out  DW  registered copy of the owner's wdata
- mem_rdata  in  DW  memory read data, valid with mem_ready
- mem_ready  in  1  memory completes the transaction this cycle

## Operation
- States: IDLE, BUSY, DONE.
- Priority pointer `last` records the last port served.

IDLE:
- Arbitration happens only in IDLE.
- If only one req is high, that port wins.
- If both are high, the port ≠ `last` wins.
- On a win: latch the winner's we/addr/wdata into mem_* registers, set the winner's gnt, set `last` = winner, clear the timeout counter, and move to BUSY.
- If no req is high, stay in IDLE.

BUSY:
- mem_req = 1. The counter increments each cycle.
- mem_ready = 1: capture mem_rdata into rdata (reads only; rdata holds on writes), set err = 0, and move to DONE.
- Counter reaches TIMEOUT−1 without mem_ready: set err = 1, leave rdata unchanged, and move to DONE.
- mem_ready on the same cycle as the timeout: mem_ready wins and err = 0.

DONE:
- The owner's done is 1 for exactly this cycle. mem_req = 0.
- Next state is IDLE; gnt and done clear.

Other rules:
- The other port's req is ignored outside IDLE. It is served at the next IDLE at the earliest.
- Protocol violation: a requester dropping req during BUSY does not abort the transaction. Done still pulses.
- Reset, at any time including mid-transaction: immediately state = IDLE and `last` = 1 (port 0 wins the first tie). All outputs go to 0: gnt0, gnt1, done0, done1, err, rdata, mem_req, mem_we, mem_addr, mem_wdata. Any in-flight memory transaction is abandoned.

## Timing
- All outputs are registered and reflect state only.
- Requesters sample done on a rising edge and must drop req in the cycle after done (i.e., at the IDLE that follows DONE). A req still high in that IDLE is a new request.
- A request first sampled high in IDLE at edge k: gnt and mem_req are high from edge k. mem_addr, mem_we and mem_wdata are valid in that same cycle.
- If mem_ready is high in the first BUSY cycle, done is high in the cycle after edge k+1. Minimum request-to-done latency is 2 cycles.
- Minimum occupancy is 3 cycles per transaction (IDLE, BUSY, DONE). Back-to-back alternation under continuous requests from both ports: 0,1,0,1,…
- Timeout abort: done rises exactly TIMEOUT cycles after entering BUSY.
- mem_ready seen outside BUSY is ignored.

## Test plan
- Reset values: drive rst_n low mid-BUSY (port 1 granted) → all outputs 0 asynchronously. Release reset, then raise req0 and req1 together → gnt0 first.
- Single read: req0, we0 = 0, addr0 = 0x40. Memory answers mem_rdata = 0xDEADBEEF with one wait cycle → mem_addr = 0x40 and mem_req high for 2 cycles. done0 pulses once with rdata = 0xDEADBEEF and err = 0. gnt1 stays 0.
- Fairness: req0 and req1 held continuously, zero-wait memory → grants alternate 0,1,0,1 over 4 transactions, each taking 3 cycles.
- Write: req1, we1 = 1, addr1 = 0x100, wdata1 = 0x12345678 → mem_we = 1 and mem_wdata = 0x12345678 while mem_req is high. done1 pulses. rdata keeps its previous value.
- Timeout: TIMEOUT = 4 and mem_ready never asserted → exactly 4 BUSY cycles, then done0 with err = 1. The next request completes normally with err = 0.
- Race: mem_ready asserted on the final timeout cycle → err = 0 and rdata captured. A req1 that rose during BUSY is served immediately after that IDLE.
